multi_timeout_ctrl: RTL and testbench
=====================================

# multi_timeout_ctrl

Parametrised, multi-channel, retriggerable timeout controller. Each channel asserts `status` for a programmable number of `tick` strobes after a trigger. It then either drops `status` (one-shot) or reloads and continues (periodic), and pulses `expired` on every expiry. It sits beside the 1 ms tick generator and serves every on-screen/game timer that needs "active for N ms" behaviour, with a per-channel clear for PC-driven restarts and a global `on` freeze.

## Interface
- `NUM_CH`, 4: number of independent timer channels.
- `CNT_W`, 10: counter/duration width in bits.
- `DURATION`, 1000: default duration in ticks, used when `duration` == 0; must be 1..2^CNT_W-1.

- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low; clears all state.
- `on` in 1: global enable; low freezes every channel.
- `tick` in 1: count strobe, one cycle wide (tie high to count clocks).
- `clear` in NUM_CH: per-channel clear to idle.
- `trigger` in NUM_CH: per-channel start/retrigger.
- `mode` in NUM_CH: per-channel mode, 0 one-shot, 1 periodic; sampled at trigger.
- `duration` in CNT_W: shared runtime duration; 0 selects `DURATION`; sampled at trigger.
- `status` out NUM_CH: channel running.
- `expired` out NUM_CH: one-cycle expiry pulse.
- `remaining` out NUM_CH*CNT_W: ticks left; channel i at bits [i*CNT_W +: CNT_W].
- `any_active` out 1: OR of `status`.

## Operation
- Per-channel state: IDLE / RUN (`status` = RUN), `remaining`, reload register `period`, latched mode bit.
- Effective duration D = (`duration` == 0) ? `DURATION` : `duration`.
- Per-channel priority, highest first:
  1. `reset` low: everything to 0.
  2. `on` low: hold all state, `expired` = 0, inputs ignored.
  3. `clear`: IDLE, `remaining` = 0, `period` unchanged, no expired pulse.
  4. `trigger`: RUN, `remaining` = D, `period` = D, latch `mode`. The same-cycle tick is ignored for that channel.
  5. `tick` in RUN:
     - if `remaining` > 1: decrement.
     - if `remaining` == 1: `expired` = 1 next cycle. One-shot goes to IDLE with `remaining` = 0. Periodic stays in RUN with `remaining` = `period`.
- `tick` in IDLE: no effect.
- Retrigger in RUN restarts the count from D with no expired pulse, even if expiry was due that cycle.
- Channels are fully independent; the shared `duration` is sampled separately by each triggering channel.
- Changing `mode` or `duration` mid-run has no effect until the next trigger.
- Arithmetic is unsigned CNT_W bits. `remaining` never wraps below 0, and never decrements in IDLE.

## Timing
- Reset values: `status` 0, `expired` 0, `remaining` 0, `any_active` 0, `period` 0, mode 0.
- All outputs are registered except `any_active`, which is combinational OR of the registered `status`.
- Trigger sampled at edge k gives `status` = 1 and `remaining` = D visible after edge k.
- One-shot with `tick` held high: `status` is high for exactly D cycles, and `expired` is high on the cycle `status` first reads 0.
- Periodic with `tick` held high: `expired` pulses every D cycles, and `status` stays 1 throughout.
- Tick strobed every M clocks: expiry occurs at the D-th tick after trigger. Latency from trigger to expiry is that tick edge.
- `on` low for any span: counts resume exactly where they stopped. An expiry due during the freeze is deferred to the first tick after `on` rises.
- Clear and trigger in the same cycle: clear wins, and the channel ends in IDLE.
- Reset low mid-run: all channels are IDLE after that edge, with no expired pulse.

## Test plan
- Reset low 2 cycles, then trigger ch0 with `duration`=0, `tick`=1, mode 0 -> `status[0]` high exactly 1000 cycles, `expired[0]` one pulse at cycle 1001, `remaining` 1000→0.
- Trigger ch1 periodic with `duration`=5 and `tick` every 3rd clock -> `expired[1]` pulses every 15 clocks, `status[1]` constant 1; clear at an arbitrary point -> `status` 0, no further pulses.
- Ch2 one-shot with `duration`=4; retrigger on the cycle `remaining`=1 with a tick -> no expired pulse, `remaining`=4, total high time = 3 + 4 ticks.
- Ch3 running at `remaining`=2, drop `on` for 50 cycles with ticks -> `remaining` stays 2, trigger/clear ignored; raise `on` -> expires after 2 more ticks.
- All channels triggered with different `duration` values (1, 2, 7, 0) -> independent expiries at ticks 1, 2, 7, 1000. Assert clear+trigger on ch0 together -> ch0 idle. `any_active` falls only after the last channel expires.
- Reset low while all channels are running -> all outputs 0 next cycle, no `expired` pulse.

Source files
------------

// File: rtl/multi_timeout_ctrl_if.sv
// Control/status bundle for multi_timeout_ctrl: per-channel start/clear/mode,
// the shared duration and the running/expiry/remaining outputs.
interface multi_timeout_ctrl_if #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 10
);
   logic                      on;
   logic                      tick;
   logic [NUM_CH-1:0]         clear;
   logic [NUM_CH-1:0]         trigger;
   logic [NUM_CH-1:0]         mode;
   logic [CNT_W-1:0]          duration;
   logic [NUM_CH-1:0]         status;
   logic [NUM_CH-1:0]         expired;
   logic [NUM_CH*CNT_W-1:0]   remaining;
   logic                      any_active;

   modport master (
      output on, tick, clear, trigger, mode, duration,
      input  status, expired, remaining, any_active
   );

   modport slave (
      input  on, tick, clear, trigger, mode, duration,
      output status, expired, remaining, any_active
   );
endinterface

// File: rtl/multi_timeout_ctrl.sv
// Multi-channel retriggerable timeout controller: each channel runs for D ticks
// after a trigger, then stops (one-shot) or reloads (periodic), pulsing expired.
module multi_timeout_ctrl_ch #(
   parameter int CNT_W = 10
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_on,
   input  logic             i_tick,
   input  logic             i_clear,
   input  logic             i_trigger,
   input  logic             i_mode,
   input  logic [CNT_W-1:0] i_dur,
   output logic             o_status,
   output logic             o_expired,
   output logic [CNT_W-1:0] o_remaining
);
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;
   localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);

   logic [0:0]       r_state;
   logic [CNT_W-1:0] r_rem;
   logic [CNT_W-1:0] r_period;
   logic             r_mode;
   logic             r_exp;

   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         r_state  <= ST_IDLE;
         r_rem    <= '0;
         r_period <= '0;
         r_mode   <= 1'b0;
         r_exp    <= 1'b0;
      end else if (!i_on) begin
         // Frozen: hold the count; a due expiry waits for the next live tick.
         r_exp <= 1'b0;
      end else begin
         r_exp <= 1'b0;
         if (i_clear) begin
            r_state <= ST_IDLE;
            r_rem   <= '0;
         end else if (i_trigger) begin
            r_state  <= ST_RUN;
            r_rem    <= i_dur;
            r_period <= i_dur;
            r_mode   <= i_mode;
         end else if (i_tick && r_state == ST_RUN) begin
            if (r_rem > LP_ONE) begin
               r_rem <= r_rem - LP_ONE;
            end else begin
               r_exp <= 1'b1;
               if (r_mode) begin
                  r_rem <= r_period;
               end else begin
                  r_state <= ST_IDLE;
                  r_rem   <= '0;
               end
            end
         end
      end
   end

   assign o_status    = (r_state == ST_RUN);
   assign o_expired   = r_exp;
   assign o_remaining = r_rem;
endmodule

module multi_timeout_ctrl #(
   parameter int NUM_CH   = 4,
   parameter int CNT_W    = 10,
   parameter int DURATION = 1000
) (
   input logic                 i_clock,
   input logic                 i_reset,
   multi_timeout_ctrl_if.slave io_bus
);
   localparam logic [CNT_W-1:0] LP_DEF_DUR = CNT_W'(DURATION);

   logic [CNT_W-1:0]             w_dur;
   logic [NUM_CH-1:0]            w_status;
   logic [NUM_CH-1:0]            w_expired;
   logic [NUM_CH-1:0][CNT_W-1:0] w_rem;

   // Zero on the shared duration bus selects the build-time default.
   assign w_dur = (io_bus.duration == '0) ? LP_DEF_DUR : io_bus.duration;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      multi_timeout_ctrl_ch #(.CNT_W(CNT_W)) u_ch (
         .i_clock     (i_clock),
         .i_reset     (i_reset),
         .i_on        (io_bus.on),
         .i_tick      (io_bus.tick),
         .i_clear     (io_bus.clear[g]),
         .i_trigger   (io_bus.trigger[g]),
         .i_mode      (io_bus.mode[g]),
         .i_dur       (w_dur),
         .o_status    (w_status[g]),
         .o_expired   (w_expired[g]),
         .o_remaining (w_rem[g])
      );
   end

   assign io_bus.status     = w_status;
   assign io_bus.expired    = w_expired;
   assign io_bus.remaining  = w_rem;
   assign io_bus.any_active = |w_status;
endmodule

// File: tb/tb_multi_timeout_ctrl.sv
// Bench for multi_timeout_ctrl: tick-count model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_multi_timeout_ctrl;
   localparam int NCH = 4;
   localparam int CW  = 10;
   localparam int DEF = 1000;

   logic clk = 1'b0;
   logic rst_n;
   int   n_chk  = 0;
   int   n_fail = 0;
   int   cyc    = 0;
   int   tick_div = 1;
   int   tcnt  = 0;
   int   exp_cnt [NCH];
   int   last_e  [NCH];
   int   gap     [NCH];

   multi_timeout_ctrl_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

   multi_timeout_ctrl #(.NUM_CH(NCH), .CNT_W(CW), .DURATION(DEF)) dut (
      .i_clock (clk),
      .i_reset (rst_n),
      .io_bus  (bus)
   );

   always #5 clk = ~clk;

   // Model: a channel is "n ticks into a D-tick run"; outputs follow from n and D.
   bit m_run [NCH];
   bit m_mode[NCH];
   bit m_exp [NCH];
   int m_n   [NCH];
   int m_D   [NCH];

   always @(posedge clk) begin
      for (int c = 0; c < NCH; c++) begin
         if (!rst_n) begin
            m_run[c] = 0; m_mode[c] = 0; m_exp[c] = 0; m_n[c] = 0; m_D[c] = 1;
         end else if (!bus.on) begin
            m_exp[c] = 0;
         end else begin
            m_exp[c] = 0;
            if (bus.clear[c]) begin
               m_run[c] = 0;
            end else if (bus.trigger[c]) begin
               m_run[c]  = 1;
               m_D[c]    = (bus.duration == 0) ? DEF : int'(bus.duration);
               m_mode[c] = bus.mode[c];
               m_n[c]    = 0;
            end else if (bus.tick && m_run[c]) begin
               m_n[c]++;
               if (m_mode[c] ? (m_n[c] % m_D[c] == 0) : (m_n[c] == m_D[c])) begin
                  m_exp[c] = 1;
                  if (!m_mode[c]) m_run[c] = 0;
               end
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      logic [NCH-1:0]    e_st, e_ex;
      logic [NCH*CW-1:0] e_rem;
      e_st = '0; e_ex = '0; e_rem = '0;
      for (int c = 0; c < NCH; c++) begin
         e_st[c] = m_run[c];
         e_ex[c] = m_exp[c];
         e_rem[c*CW +: CW] = m_run[c] ? CW'(m_D[c] - (m_n[c] % m_D[c])) : '0;
      end
      chk("status", 64'(bus.status), 64'(e_st));
      chk("expired", 64'(bus.expired), 64'(e_ex));
      chk("remaining", 64'(bus.remaining), 64'(e_rem));
      chk("any_active", 64'(bus.any_active), 64'(|e_st));
   end

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         bus.tick = (tcnt == 0);
         tcnt = (tcnt + 1) % tick_div;
         step();
         for (int c = 0; c < NCH; c++) begin
            if (bus.expired[c]) begin
               if (last_e[c] >= 0) gap[c] = cyc - last_e[c];
               last_e[c] = cyc;
               exp_cnt[c]++;
            end
         end
      end
   endtask

   task automatic clr_track();
      for (int c = 0; c < NCH; c++) begin
         exp_cnt[c] = 0; last_e[c] = -1; gap[c] = 0;
      end
   endtask

   function automatic logic [CW-1:0] rem(input int c);
      logic [NCH*CW-1:0] r;
      r = bus.remaining;
      return r[c*CW +: CW];
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int cnt;
      int et [NCH];
      logic [CW-1:0] durs [NCH];
      rst_n = 1'b0;
      bus.on = 1'b0; bus.tick = 1'b0; bus.clear = '0; bus.trigger = '0;
      bus.mode = '0; bus.duration = '0;
      clr_track();
      step(); step();
      chk("rst_status", 64'(bus.status), 64'd0);
      chk("rst_rem", 64'(bus.remaining), 64'd0);

      // One-shot, default duration, tick held high.
      rst_n = 1'b1; bus.on = 1'b1; tick_div = 1; tcnt = 0;
      bus.trigger = 4'b0001; bus.duration = '0;
      run(1);
      bus.trigger = '0;
      chk("t1_rem_start", 64'(rem(0)), 64'd1000);
      cnt = 0;
      while (bus.status[0] && cnt < 2000) begin run(1); cnt++; end
      chk("t1_high_cycles", 64'(cnt), 64'd1000);
      chk("t1_expired", 64'(bus.expired[0]), 64'd1);
      chk("t1_rem_end", 64'(rem(0)), 64'd0);
      run(1);
      chk("t1_expired_drop", 64'(bus.expired[0]), 64'd0);

      // Periodic, duration 5, tick every 3rd clock.
      tick_div = 3; tcnt = 1;
      bus.trigger = 4'b0010; bus.mode = 4'b0010; bus.duration = 10'd5;
      run(1);
      bus.trigger = '0; tcnt = 0;
      clr_track();
      run(62);
      chk("t2_pulses", 64'(exp_cnt[1]), 64'd4);
      chk("t2_period", 64'(gap[1]), 64'd15);
      chk("t2_status", 64'(bus.status[1]), 64'd1);
      bus.clear = 4'b0010;
      run(1);
      bus.clear = '0;
      chk("t2_clr_status", 64'(bus.status[1]), 64'd0);
      clr_track();
      run(40);
      chk("t2_no_pulse", 64'(exp_cnt[1]), 64'd0);

      // One-shot duration 4, retrigger on the remaining==1 cycle.
      tick_div = 1; tcnt = 0; bus.mode = '0; bus.duration = 10'd4;
      bus.trigger = 4'b0100;
      run(1);
      bus.trigger = '0;
      cnt = 0;
      while (rem(2) != 1 && cnt < 10) begin run(1); cnt++; end
      chk("t3_reach_one", 64'(cnt), 64'd3);
      bus.trigger = 4'b0100;
      run(1);
      bus.trigger = '0;
      chk("t3_rem_retrig", 64'(rem(2)), 64'd4);
      chk("t3_no_exp", 64'(bus.expired[2]), 64'd0);
      cnt = 0;
      while (bus.status[2] && cnt < 20) begin run(1); cnt++; end
      chk("t3_second_run", 64'(cnt), 64'd4);
      chk("t3_expired", 64'(bus.expired[2]), 64'd1);

      // Freeze with on low while ch3 sits at remaining 2.
      bus.duration = 10'd5; bus.trigger = 4'b1000;
      run(1);
      bus.trigger = '0;
      run(3);
      chk("t4_rem2", 64'(rem(3)), 64'd2);
      bus.on = 1'b0;
      for (int i = 0; i < 50; i++) begin
         bus.trigger = (i == 10) ? 4'b1000 : 4'b0000;
         bus.clear   = (i == 20) ? 4'b1000 : 4'b0000;
         run(1);
      end
      bus.trigger = '0; bus.clear = '0;
      chk("t4_frozen_rem", 64'(rem(3)), 64'd2);
      chk("t4_frozen_st", 64'(bus.status[3]), 64'd1);
      bus.on = 1'b1;
      run(1);
      chk("t4_rem1", 64'(rem(3)), 64'd1);
      run(1);
      chk("t4_expired", 64'(bus.expired[3]), 64'd1);
      chk("t4_idle", 64'(bus.status[3]), 64'd0);

      // All channels, durations 1,2,7,0(default).
      durs[0] = 10'd1; durs[1] = 10'd2; durs[2] = 10'd7; durs[3] = 10'd0;
      bus.tick = 1'b0;
      for (int c = 0; c < NCH; c++) begin
         bus.duration = durs[c];
         bus.trigger = '0; bus.trigger[c] = 1'b1;
         step();
         et[c] = -1;
      end
      bus.trigger = '0;
      tcnt = 0;
      for (int t = 1; t <= 1002; t++) begin
         if (t == 10) begin bus.clear = 4'b0001; bus.trigger = 4'b0001; bus.duration = 10'd3; end
         run(1);
         bus.clear = '0; bus.trigger = '0;
         if (t == 10) chk("t5_clr_trig_idle", 64'(bus.status[0]), 64'd0);
         for (int c = 0; c < NCH; c++) if (bus.expired[c] && et[c] < 0) et[c] = t;
         if (t == 999) chk("t5_any_999", 64'(bus.any_active), 64'd1);
      end
      chk("t5_exp0", 64'(et[0]), 64'd1);
      chk("t5_exp1", 64'(et[1]), 64'd2);
      chk("t5_exp2", 64'(et[2]), 64'd7);
      chk("t5_exp3", 64'(et[3]), 64'd1000);
      chk("t5_any_end", 64'(bus.any_active), 64'd0);

      // Reset while everything is running.
      bus.duration = 10'd10; bus.mode = 4'b1010; bus.trigger = 4'b1111;
      run(1);
      bus.trigger = '0;
      run(3);
      chk("t6_all_run", 64'(bus.status), 64'hF);
      rst_n = 1'b0;
      run(1);
      chk("t6_status", 64'(bus.status), 64'd0);
      chk("t6_expired", 64'(bus.expired), 64'd0);
      chk("t6_rem", 64'(bus.remaining), 64'd0);
      chk("t6_any", 64'(bus.any_active), 64'd0);
      rst_n = 1'b1;
      run(5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
